// File: rtl/coherence_line_ctrl.sv
// coherence_line_ctrl: per-line MSI/MESI state and tag array with a single-request bus FSM.
// Snoops act on the array every cycle; a local grant update on the same line takes priority.
module coherence_line_ctrl #(
  parameter int INDEX_W = 4,
  parameter int TAG_W = 8,
  parameter int MESI = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cpu_req_valid,
  output logic               cpu_req_ready,
  input  logic               cpu_req_we,
  input  logic [INDEX_W-1:0] cpu_req_index,
  input  logic [TAG_W-1:0]   cpu_req_tag,
  output logic               cpu_done,
  output logic               bus_req_valid,
  output logic [1:0]         bus_req_cmd,
  output logic [INDEX_W-1:0] bus_req_index,
  output logic [TAG_W-1:0]   bus_req_tag,
  input  logic               bus_grant,
  input  logic               bus_shared,
  input  logic               snoop_valid,
  input  logic [1:0]         snoop_cmd,
  input  logic [INDEX_W-1:0] snoop_index,
  input  logic [TAG_W-1:0]   snoop_tag,
  output logic               snoop_flush,
  input  logic [INDEX_W-1:0] dbg_index,
  output logic [1:0]         dbg_state
);
  localparam int N = 1 << INDEX_W;
  typedef enum logic [1:0] {LI = 2'b00, LM = 2'b01, LS = 2'b10, LE = 2'b11} line_t;
  typedef enum logic [2:0] {IDLE, WB, MISS, UPG, DONE} fsm_t;
  fsm_t fsm;
  line_t st [N];
  logic [TAG_W-1:0] tg [N];
  logic r_we;
  logic [INDEX_W-1:0] r_index, lu_idx;
  logic [TAG_W-1:0] r_tag;
  line_t req_st, sn_st, lu_st;
  logic acc, req_hit, grant, lu_en, lu_tag, sn_hit, sn_rd, sn_inv, sn_act, flush_n, upg_lost;
  assign cpu_req_ready = fsm == IDLE;
  assign dbg_state = st[dbg_index];
  always_comb begin
    acc = cpu_req_valid && fsm == IDLE;
    req_st = st[cpu_req_index];
    req_hit = req_st != LI && tg[cpu_req_index] == cpu_req_tag;
    grant = bus_req_valid && bus_grant;
    lu_en = (acc && req_hit && cpu_req_we && req_st == LE) || (grant && (fsm == UPG || fsm == MISS));
    lu_idx = acc ? cpu_req_index : r_index;
    lu_st = (fsm == MISS && !r_we) ? ((MESI != 0 && !bus_shared) ? LE : LS) : LM;
    lu_tag = grant && fsm == MISS;
    sn_st = st[snoop_index];
    sn_hit = snoop_valid && sn_st != LI && tg[snoop_index] == snoop_tag;
    sn_rd = snoop_cmd == 2'b10;
    sn_inv = !snoop_cmd[1];
    sn_act = sn_hit && (sn_rd || sn_inv) && !(lu_en && snoop_index == lu_idx);
    flush_n = sn_act && sn_st == LM;
    // The S copy we meant to upgrade is gone (snooped now or at acceptance): fetch it instead.
    upg_lost = fsm == UPG && !grant &&
               ((sn_act && sn_inv && snoop_index == r_index) || st[r_index] == LI || tg[r_index] != r_tag);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        st[i] <= LI;
        tg[i] <= '0;
      end
    end else begin
      if (sn_act) st[snoop_index] <= sn_rd ? LS : LI;
      if (lu_en) st[lu_idx] <= lu_st;
      if (lu_tag) tg[lu_idx] <= r_tag;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      fsm <= IDLE;
      r_we <= 1'b0;
      r_index <= '0;
      r_tag <= '0;
      cpu_done <= 1'b0;
      snoop_flush <= 1'b0;
      bus_req_valid <= 1'b0;
      bus_req_cmd <= 2'b00;
      bus_req_index <= '0;
      bus_req_tag <= '0;
    end else begin
      snoop_flush <= flush_n;
      cpu_done <= 1'b0;
      case (fsm)
        IDLE: if (acc) begin
          r_we <= cpu_req_we;
          r_index <= cpu_req_index;
          r_tag <= cpu_req_tag;
          fsm <= req_hit ? ((cpu_req_we && req_st == LS) ? UPG : DONE) : (req_st == LM ? WB : MISS);
          cpu_done <= req_hit && !(cpu_req_we && req_st == LS);
        end
        WB: if (!bus_req_valid) begin
          bus_req_valid <= 1'b1;
          bus_req_cmd <= 2'b11;
          bus_req_index <= r_index;
          bus_req_tag <= tg[r_index];
        end else if (bus_grant) begin
          bus_req_valid <= 1'b0;
          fsm <= MISS;
        end
        MISS: if (!bus_req_valid) begin
          bus_req_valid <= 1'b1;
          bus_req_cmd <= r_we ? 2'b01 : 2'b10;
          bus_req_index <= r_index;
          bus_req_tag <= r_tag;
        end else if (bus_grant) begin
          bus_req_valid <= 1'b0;
          fsm <= DONE;
          cpu_done <= 1'b1;
        end
        UPG: if (upg_lost) begin
          fsm <= MISS;
          bus_req_cmd <= 2'b01;
        end else if (!bus_req_valid) begin
          bus_req_valid <= 1'b1;
          bus_req_cmd <= 2'b00;
          bus_req_index <= r_index;
          bus_req_tag <= r_tag;
        end else if (bus_grant) begin
          bus_req_valid <= 1'b0;
          fsm <= DONE;
          cpu_done <= 1'b1;
        end
        DONE: fsm <= IDLE;
        default: fsm <= IDLE;
      endcase
    end
endmodule
